// File: rtl/song_player_if.sv
// Song ROM read bus between the player and a synchronous song ROM.
// The player drives the address; the ROM returns data one clock later.
interface song_player_if;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/song_player.sv
// Song sequencer: walks a 64-entry song in ROM, times each note and gap,
// and handles auto-play enable, pause and previous/next song buttons.
module song_player #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int SONG_NUM    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        btn_prev,
  input  logic        btn_pause,
  input  logic        btn_next,
  song_player_if.master rom,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic [1:0]  song_idx,
  output logic        playing,
  output logic [6:0]  led
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_PAUSE,
    S_END
  } state_t;

  localparam logic [31:0] UNIT_W = 32'(UNIT_CYCLES);
  localparam logic [31:0] GAP_W  = 32'(GAP_CYCLES);
  localparam logic [1:0]  LAST   = 2'(SONG_NUM - 1);

  state_t      state_q;
  state_t      ret_q;
  logic [1:0]  song_q;
  logic [5:0]  off_q;
  logic [3:0]  note_q;
  logic        nv_q;
  logic [31:0] cnt_q;
  logic [2:0]  btn_q;
  logic        armed_q;

  logic [2:0]  rise;
  logic        prv_e;
  logic        pau_e;
  logic        nxt_e;
  logic [1:0]  song_d;
  logic [3:0]  dur;
  logic [31:0] load_d;
  logic [3:0]  nm1;
  logic [2:0]  led_idx;

  // armed_q masks the first sample so a button held through reset is no edge
  assign rise  = {btn_prev, btn_pause, btn_next} & ~btn_q & {3{armed_q}};
  assign prv_e = rise[2];
  assign pau_e = rise[1];
  assign nxt_e = rise[0];

  assign dur    = rom.rom_data[7:4];
  assign load_d = 32'(dur) * UNIT_W;

  always_comb begin
    song_d = song_q;
    if (nxt_e) begin
      song_d = (song_q == LAST) ? 2'd0 : song_q + 2'd1;
    end else if (prv_e) begin
      song_d = (song_q == 2'd0) ? LAST : song_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_PLAY;
      song_q  <= 2'd0;
      off_q   <= 6'd0;
      note_q  <= 4'd0;
      nv_q    <= 1'b0;
      cnt_q   <= 32'd0;
      btn_q   <= 3'b000;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= {btn_prev, btn_pause, btn_next};
      armed_q <= 1'b1;
      if (!en) begin
        state_q <= S_IDLE;
        off_q   <= 6'd0;
        note_q  <= 4'd0;
        nv_q    <= 1'b0;
        cnt_q   <= 32'd0;
      end else if (state_q != S_IDLE && (nxt_e || prv_e)) begin
        state_q <= S_FETCH;
        song_q  <= song_d;
        off_q   <= 6'd0;
        note_q  <= 4'd0;
        nv_q    <= 1'b0;
        cnt_q   <= 32'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_FETCH;
            off_q   <= 6'd0;
          end
          S_FETCH: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (dur == 4'd0) begin
              state_q <= S_END;
              note_q  <= 4'd0;
              nv_q    <= 1'b0;
            end else begin
              state_q <= S_PLAY;
              note_q  <= rom.rom_data[3:0];
              nv_q    <= (rom.rom_data[3:0] != 4'd0);
              cnt_q   <= load_d;
            end
          end
          S_PLAY: begin
            // the cycle ending in a pause edge still counts as played
            if (pau_e) begin
              state_q <= S_PAUSE;
              nv_q    <= 1'b0;
              if (cnt_q == 32'd1) begin
                ret_q <= S_GAP;
                cnt_q <= GAP_W;
              end else begin
                ret_q <= S_PLAY;
                cnt_q <= cnt_q - 32'd1;
              end
            end else if (cnt_q == 32'd1) begin
              state_q <= S_GAP;
              nv_q    <= 1'b0;
              cnt_q   <= GAP_W;
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end
          S_GAP: begin
            if (cnt_q == 32'd1) begin
              cnt_q <= 32'd0;
              if (off_q == 6'd63) begin
                state_q <= S_END;
                note_q  <= 4'd0;
              end else begin
                state_q <= S_FETCH;
                off_q   <= off_q + 6'd1;
              end
            end else if (pau_e) begin
              state_q <= S_PAUSE;
              ret_q   <= S_GAP;
              cnt_q   <= cnt_q - 32'd1;
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end
          S_PAUSE: begin
            if (pau_e) begin
              state_q <= ret_q;
              nv_q    <= (ret_q == S_PLAY) && (note_q != 4'd0);
            end
          end
          S_END: begin
            note_q <= 4'd0;
            nv_q   <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            nv_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom.rom_addr = {song_q, off_q};
  assign note         = note_q;
  assign note_valid   = nv_q;
  assign song_idx     = song_q;
  assign playing      = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                        (state_q == S_PLAY)  || (state_q == S_GAP);

  assign nm1     = note_q - 4'd1;
  assign led_idx = 3'(nm1 % 4'd7);

  always_comb begin
    led = 7'd0;
    if (nv_q) begin
      led = 7'd1 << led_idx;
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a small synchronous ROM model.
// Fast parameters: 4 cycles per unit, 2 gap cycles, 2 songs.
module tb_song_player;

  logic       clk;
  logic       rst;
  logic       en;
  logic       btn_prev;
  logic       btn_pause;
  logic       btn_next;
  logic [3:0] note;
  logic       note_valid;
  logic [1:0] song_idx;
  logic       playing;
  logic [6:0] led;

  logic [7:0] mem [256];
  int         n_chk;
  int         n_err;

  song_player_if rif ();

  song_player #(
    .UNIT_CYCLES (4),
    .GAP_CYCLES  (2),
    .SONG_NUM    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .btn_prev   (btn_prev),
    .btn_pause  (btn_pause),
    .btn_next   (btn_next),
    .rom        (rif),
    .note       (note),
    .note_valid (note_valid),
    .song_idx   (song_idx),
    .playing    (playing),
    .led        (led)
  );

  always_ff @(posedge clk) begin
    rif.rom_data <= mem[rif.rom_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nv(input int lim);
    int k;
    k = 0;
    while (!note_valid && k < lim) begin
      tick();
      k++;
    end
    chk("wait_nv", 32'(note_valid), 32'd1);
  endtask

  task automatic run_len(output int n);
    n = 0;
    while (note_valid && n < 64) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int g;
    int k;
    int hi;
    int notes;
    logic pv;
    logic [6:0] first_led;

    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b0;
    btn_prev  = 1'b0;
    btn_pause = 1'b0;
    btn_next  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]  = 8'h23;
    mem[1]  = 8'h00;
    mem[64] = 8'h45;
    mem[65] = 8'h00;

    #1;
    chk("rst_nv",   32'(note_valid),   32'd0);
    chk("rst_play", 32'(playing),      32'd0);
    chk("rst_song", 32'(song_idx),     32'd0);
    chk("rst_addr", 32'(rif.rom_addr), 32'd0);
    chk("rst_note", 32'(note),         32'd0);
    chk("rst_led",  32'(led),          32'd0);

    tick();
    rst = 1'b0;
    tick();
    tick();

    // single note then end-of-song marker
    en = 1'b1;
    tick();
    chk("fetch_play", 32'(playing),      32'd1);
    chk("fetch_addr", 32'(rif.rom_addr), 32'd0);
    tick();
    tick();
    chk("load_note", 32'(note),       32'd3);
    chk("load_nv",   32'(note_valid), 32'd1);
    chk("load_led",  32'(led),        32'b0000100);
    run_len(n);
    chk("note_len", 32'(n), 32'd8);
    g = 0;
    while (rif.rom_addr == 8'd0 && playing && g < 16) begin
      g++;
      tick();
    end
    chk("gap_len", 32'(g), 32'd2);
    k = 0;
    while (playing && k < 10) begin
      tick();
      k++;
    end
    chk("end_play", 32'(playing),    32'd0);
    chk("end_note", 32'(note),       32'd0);
    chk("end_nv",   32'(note_valid), 32'd0);
    en = 1'b0;
    tick();

    // pause 3 cycles in, hold 10 cycles, resume for the remaining 5
    en = 1'b1;
    wait_nv(10);
    tick();
    tick();
    btn_pause = 1'b1;
    tick();
    chk("pause_nv",   32'(note_valid), 32'd0);
    chk("pause_play", 32'(playing),    32'd0);
    btn_pause = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (note_valid) hi++;
    end
    chk("paused_low", 32'(hi), 32'd0);
    btn_pause = 1'b1;
    tick();
    run_len(n);
    chk("resume_len", 32'(n), 32'd5);
    btn_pause = 1'b0;
    en = 1'b0;
    tick();

    // next / prev with wraparound
    en = 1'b1;
    wait_nv(10);
    btn_next = 1'b1;
    tick();
    chk("next_song", 32'(song_idx),     32'd1);
    chk("next_addr", 32'(rif.rom_addr), 32'd64);
    chk("next_nv",   32'(note_valid),   32'd0);
    btn_next = 1'b0;
    wait_nv(10);
    chk("s1_note", 32'(note), 32'd5);
    chk("s1_led",  32'(led),  32'b0010000);
    btn_next = 1'b1;
    tick();
    chk("wrap_song", 32'(song_idx),     32'd0);
    chk("wrap_addr", 32'(rif.rom_addr), 32'd0);
    btn_next = 1'b0;
    tick();
    btn_prev = 1'b1;
    tick();
    chk("prev_song", 32'(song_idx),     32'd1);
    chk("prev_addr", 32'(rif.rom_addr), 32'd64);
    btn_prev = 1'b0;

    // next and pause together: song change wins
    wait_nv(10);
    btn_next  = 1'b1;
    btn_pause = 1'b1;
    tick();
    chk("np_song", 32'(song_idx),     32'd0);
    chk("np_addr", 32'(rif.rom_addr), 32'd0);
    chk("np_play", 32'(playing),      32'd1);
    chk("np_nv",   32'(note_valid),   32'd0);
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    tick();
    tick();
    chk("np_reload_nv",   32'(note_valid), 32'd1);
    chk("np_reload_note", 32'(note),       32'd3);

    // enable drop keeps the song, discards position
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    wait_nv(10);
    en = 1'b0;
    tick();
    chk("enlo_song", 32'(song_idx),   32'd1);
    chk("enlo_play", 32'(playing),    32'd0);
    chk("enlo_note", 32'(note),       32'd0);
    chk("enlo_nv",   32'(note_valid), 32'd0);
    en = 1'b1;
    tick();
    chk("enhi_addr", 32'(rif.rom_addr), 32'd64);

    // asynchronous reset between clock edges
    wait_nv(10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_nv",   32'(note_valid),   32'd0);
    chk("arst_play", 32'(playing),      32'd0);
    chk("arst_song", 32'(song_idx),     32'd0);
    chk("arst_addr", 32'(rif.rom_addr), 32'd0);
    chk("arst_led",  32'(led),          32'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // full 64-entry song: leading rest, then 63 high-do notes
    mem[64] = 8'h20;
    for (int i = 65; i < 128; i++) mem[i] = 8'h18;
    en = 1'b1;
    tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    notes = 0;
    pv = 1'b0;
    first_led = 7'd0;
    k = 0;
    while (playing && k < 1000) begin
      if (note_valid && !pv) begin
        notes++;
        if (notes == 1) first_led = led;
      end
      pv = note_valid;
      tick();
      k++;
    end
    chk("full_notes", 32'(notes),     32'd63);
    chk("full_led",   32'(first_led), 32'b0000001);
    chk("full_end",   32'(playing),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12_500_000, meaning clock cycles per duration unit (125 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 1_000_000, meaning silent cycles inserted after every note.
REQ-003 SHALL have parameter SONG_NUM, default 4 (range 1..4), meaning number of songs in ROM.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports listed below, clock and reset first.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  auto-play mode enable, level.
REQ-008 btn_prev, btn_pause, btn_next  input  1 each  debounced levels; the block acts on rising edges only.
REQ-009 rom_addr  output  8  song ROM address; song s occupies base s*64 .. s*64+63.
REQ-010 rom_data  input  8  synchronous ROM read data: [7:4] duration units, [3:0] note code (0 rest, 1-7 do..si low, 8-14 do..si high).
REQ-011 note  output  4  current note code to the tone generator.
REQ-012 note_valid  output  1  high while a non-rest note sounds.
REQ-013 song_idx  output  2  currently selected song.
REQ-014 playing  output  1  high in FETCH, WAIT, PLAY, GAP.
REQ-015 led  output  7  one-hot of ((note-1) mod 7) while note_valid, else 0.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, PLAY, GAP, PAUSE, END.
REQ-017 IDLE with en=1 at an edge -> FETCH, rom_addr=song_idx*64.
REQ-018 FETCH -> WAIT -> load: rom_data SHALL be sampled on the second edge after rom_addr changes.
REQ-019 On load: duration==0 -> END; otherwise PLAY with note=rom_data[3:0] and a 32-bit counter loaded with duration*UNIT_CYCLES.
REQ-020 PLAY: note_valid = (note!=0); counter decrements each cycle; on reaching 1 -> GAP.
REQ-021 GAP: note_valid=0 for exactly GAP_CYCLES cycles, note held; then offset+1 and FETCH; if offset was 63 -> END instead.
REQ-022 END: note_valid=0, playing=0, note=0; held until next/prev edge or en low.
REQ-023 Pause edge in PLAY or GAP -> PAUSE: counter frozen, note_valid=0, return state saved; pause edge in PAUSE resumes saved state with remaining count unchanged.
REQ-024 Pause edge in IDLE, FETCH, WAIT or END SHALL be ignored.
REQ-025 Next edge in any state except IDLE: song_idx=(song_idx+1) mod SONG_NUM, rom_addr=new base, note_valid=0, -> FETCH.
REQ-026 Prev edge: song_idx=song_idx-1, wrapping 0 -> SONG_NUM-1; otherwise as REQ-025.
REQ-027 Simultaneous edges: next wins over prev; prev/next win over pause (no pause entered).
REQ-028 en low at any edge -> IDLE next cycle, note_valid=0, note=0, song_idx retained, position discarded.
REQ-029 Duration product SHALL be computed at 32 bits without overflow for dur<=15 and default UNIT_CYCLES.

Reset
REQ-030 rst high SHALL immediately, without clock, force IDLE, song_idx=0, rom_addr=0, note=0, note_valid=0, playing=0, led=0, counter=0, edge detectors cleared (button held during reset release is not an edge).

Verification (UNIT_CYCLES=4, GAP_CYCLES=2, SONG_NUM=2)
REQ-031 Reset asserted -> all outputs 0 with no clock edge.
REQ-032 ROM[0]=0x23, ROM[1]=0x00, en rises -> note=3, note_valid high 8 cycles, led=0000100, 2 gap cycles, then END, playing=0.
REQ-033 Pause edge 3 cycles into the 8-cycle note, released, pause again after 10 cycles -> note_valid low while paused, then high exactly 5 more cycles.
REQ-034 Song 1 playing, next edge -> song_idx=0, rom_addr=0; then prev edge -> song_idx=1, rom_addr=64.
REQ-035 next and pause edges in same cycle during PLAY -> song changes, state FETCH, not PAUSE.
REQ-036 rst asserted mid-PLAY between clock edges -> note_valid, playing, song_idx drop to 0 immediately.
